q_tile_ring_buffer: RTL and testbench
=====================================

Q_TILE_RING_BUFFER -- requirements
Module: q_tile_ring_buffer

Interface
REQ-001 SHALL have parameter NUM_PES, default `NUM_PES, Q-vector slots per bank (one per PE), >=2.
REQ-002 SHALL have parameter Q_WIDTH, default `MAX_EMBEDDING_DIM*`INTEGER_WIDTH, bits per Q vector.
REQ-003 SHALL have parameter NUM_BANKS, default 3, bank count, >=2; BID_W = max(1,$clog2(NUM_BANKS)).
REQ-004 SHALL have ports:
  clk  in  1  sole clock, rising edge
  rst  in  1  reset; asynchronous, active-high
  load_valid  in  1  load_data valid
  load_data  in  Q_WIDTH  one Q vector
  load_last  in  1  qualifies load_valid; vector closes the current tile
  load_ready  out  1  fill bank can accept
  compute_start  in  1  pulse: activate oldest full bank
  compute_done  in  1  pulse: release active bank
  flush  in  1  pulse: discard all contents
  tile_ready  out  1  oldest-unconsumed bank is full
  compute_active  out  1  a bank is presented to PEs
  active_bank_id  out  BID_W  index of presented bank
  active_count  out  $clog2(NUM_PES+1)  valid vectors in presented tile
  pe_valid_mask  out  NUM_PES  bit i = slice i valid
  q_to_pes  out  NUM_PES*Q_WIDTH  PE i on [i*Q_WIDTH +: Q_WIDTH]
  tiles_pending  out  $clog2(NUM_BANKS+1)  banks in FULL state

Function
REQ-005 Each bank SHALL hold state EMPTY, FILLING, FULL or ACTIVE plus registered tile count 1..NUM_PES.
REQ-006 Fill pointer fp and read pointer rp SHALL advance modulo NUM_BANKS, fp on tile close, rp on compute_done; tiles consumed strictly in fill order.
REQ-007 load_ready SHALL be 1 iff bank[fp] is EMPTY or FILLING, from registered state only (no combinational path from inputs).
REQ-008 On load_valid&&load_ready: write load_data to bank[fp] slot wr_idx; bank[fp] EMPTY->FILLING.
REQ-009 Tile close when accepted beat has wr_idx==NUM_PES-1 or load_last=1: bank[fp]->FULL, count<=wr_idx+1, wr_idx<=0, fp advances; load_last on wr_idx 0 yields a 1-vector tile.
REQ-010 load_last without load_valid SHALL be ignored.
REQ-011 tile_ready SHALL be 1 iff bank[rp] is FULL; tiles_pending SHALL equal number of FULL banks.
REQ-012 compute_start with tile_ready=1 and compute_active=0 SHALL set bank[rp] ACTIVE; next cycle compute_active=1, active_bank_id=rp, active_count=bank count; otherwise ignored.
REQ-013 compute_done with compute_active=1 SHALL set bank[rp] EMPTY, advance rp, clear compute_active next cycle; ignored when compute_active=0.
REQ-014 compute_start and compute_done in same cycle: done SHALL be processed, start ignored.
REQ-015 Bank freed by compute_done SHALL become loadable the following cycle; load and done in same cycle on different banks both take effect.
REQ-016 q_to_pes slice i SHALL equal active-bank slot i when compute_active=1 and i<active_count, else zero; pe_valid_mask bit i uses same condition; active_count=0 when compute_active=0.
REQ-017 Presented data SHALL stay stable while compute_active=1 regardless of load activity.
REQ-018 flush SHALL (next cycle) set all banks EMPTY, fp=rp=wr_idx=0, compute_active=0; flush has priority over all same-cycle inputs, including that cycle's load beat (dropped).
REQ-019 Data storage SHALL not require reset; only control state is reset.

Reset
REQ-020 While rst=1 (asynchronous assert): banks EMPTY, fp=rp=wr_idx=0, load_ready=1, tile_ready=0, compute_active=0, active_bank_id=0, active_count=0, pe_valid_mask=0, q_to_pes=0, tiles_pending=0.
REQ-021 rst asserted mid-tile or mid-compute SHALL discard all tiles; first accepted beat after release writes bank 0 slot 0.

Verification (NUM_PES=4, NUM_BANKS=3, Q_WIDTH=16)
REQ-022 Load 4 beats 0x11..0x44, compute_start -> tile_ready=1 after beat 4; next cycle compute_active=1, id=0, active_count=4, mask=4'b1111, q_to_pes=0x0044_0033_0022_0011.
REQ-023 Load 12 beats with no compute -> tiles_pending=3, load_ready=0 after beat 12; beat 13 held off; one compute_start+compute_done -> load_ready=1 next cycle, beat 13 lands in bank 0.
REQ-024 Beats 0xA1,0xA2 with load_last on 2nd, then start -> active_count=2, mask=4'b0011, slices 2,3 zero; next tile fills bank 1 slot 0.
REQ-025 compute_start and compute_done same cycle while active with second tile pending -> active cleared, rp advances, no new activation that cycle; start next cycle activates bank 1.
REQ-026 flush with bank 0 ACTIVE, bank 1 FULL, bank 2 FILLING plus concurrent load beat -> next cycle all outputs at reset values, tiles_pending=0; following tile writes bank 0.
REQ-027 rst pulse mid-fill (wr_idx=2) -> outputs at reset values asynchronously; reload 4 beats -> tile in bank 0, count 4.

Source files
------------

// File: rtl/q_tile_ring_buffer.sv
// Q-tile ring buffer: a small ring of banks, each holding one tile of Q vectors
// (one slot per PE). A loader fills banks in order. A compute engine consumes
// the tiles in the same order and presents the oldest full tile to the PE array.

`ifndef NUM_PES
`define NUM_PES 4
`endif
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 2
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

module q_tile_ring_buffer #(
  parameter int NUM_PES   = `NUM_PES,
  parameter int Q_WIDTH   = `MAX_EMBEDDING_DIM * `INTEGER_WIDTH,
  parameter int NUM_BANKS = 3,
  localparam int BID_W    = ($clog2(NUM_BANKS) < 1) ? 1 : $clog2(NUM_BANKS),
  localparam int CNT_W    = $clog2(NUM_PES + 1),
  localparam int PEND_W   = $clog2(NUM_BANKS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [Q_WIDTH-1:0]         load_data,
  input  logic                       load_last,
  output logic                       load_ready,
  input  logic                       compute_start,
  input  logic                       compute_done,
  input  logic                       flush,
  output logic                       tile_ready,
  output logic                       compute_active,
  output logic [BID_W-1:0]           active_bank_id,
  output logic [CNT_W-1:0]           active_count,
  output logic [NUM_PES-1:0]         pe_valid_mask,
  output logic [NUM_PES*Q_WIDTH-1:0] q_to_pes,
  output logic [PEND_W-1:0]          tiles_pending
);

  localparam int IDX_W = ($clog2(NUM_PES) < 1) ? 1 : $clog2(NUM_PES);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_ACTIVE
  } bank_state_e;

  bank_state_e      bankState_q [NUM_BANKS];
  bank_state_e      bankState_d [NUM_BANKS];
  logic [CNT_W-1:0] bankCount_q [NUM_BANKS];
  logic [CNT_W-1:0] bankCount_d [NUM_BANKS];
  logic [BID_W-1:0] fp_q, fp_d;
  logic [BID_W-1:0] rp_q, rp_d;
  logic [IDX_W-1:0] wrIdx_q, wrIdx_d;
  logic             active_q, active_d;

  // Vector storage carries no reset; only the control state decides what is valid.
  logic [Q_WIDTH-1:0] slotData_q [NUM_BANKS][NUM_PES];

  logic loadFire;
  logic tileClose;

  function automatic logic [BID_W-1:0] nextBank(input logic [BID_W-1:0] idx);
    if (idx == BID_W'(NUM_BANKS - 1)) begin
      nextBank = '0;
    end else begin
      nextBank = idx + BID_W'(1);
    end
  endfunction

  // load_ready is derived from registered state only, so acceptance never
  // depends combinationally on any input.
  assign load_ready = (bankState_q[fp_q] == BANK_EMPTY) ||
                      (bankState_q[fp_q] == BANK_FILLING);
  assign loadFire   = load_valid && load_ready;
  assign tileClose  = loadFire && ((wrIdx_q == IDX_W'(NUM_PES - 1)) || load_last);

  // Control state register: banks, pointers and the active flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bankState_q[b] <= BANK_EMPTY;
        bankCount_q[b] <= '0;
      end
      fp_q     <= '0;
      rp_q     <= '0;
      wrIdx_q  <= '0;
      active_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bankState_q[b] <= bankState_d[b];
        bankCount_q[b] <= bankCount_d[b];
      end
      fp_q     <= fp_d;
      rp_q     <= rp_d;
      wrIdx_q  <= wrIdx_d;
      active_q <= active_d;
    end
  end

  // Next-state logic: flush dominates; otherwise the loader works on bank[fp] and
  // the compute side on bank[rp]. Those are always different banks when both act.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bankState_d[b] = bankState_q[b];
      bankCount_d[b] = bankCount_q[b];
    end
    fp_d     = fp_q;
    rp_d     = rp_q;
    wrIdx_d  = wrIdx_q;
    active_d = active_q;

    if (flush) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bankState_d[b] = BANK_EMPTY;
      end
      fp_d     = '0;
      rp_d     = '0;
      wrIdx_d  = '0;
      active_d = 1'b0;
    end else begin
      if (loadFire) begin
        if (tileClose) begin
          bankState_d[fp_q] = BANK_FULL;
          bankCount_d[fp_q] = CNT_W'(wrIdx_q) + CNT_W'(1);
          wrIdx_d           = '0;
          fp_d              = nextBank(fp_q);
        end else begin
          bankState_d[fp_q] = BANK_FILLING;
          wrIdx_d           = wrIdx_q + IDX_W'(1);
        end
      end

      // A done in the same cycle as a start wins; the start is simply dropped.
      if (compute_done && active_q) begin
        bankState_d[rp_q] = BANK_EMPTY;
        rp_d              = nextBank(rp_q);
        active_d          = 1'b0;
      end else if (compute_start && tile_ready && !active_q) begin
        bankState_d[rp_q] = BANK_ACTIVE;
        active_d          = 1'b1;
      end
    end
  end

  // Vector storage write: one slot per accepted beat, dropped when flushing.
  always_ff @(posedge clk) begin
    if (loadFire && !flush) begin
      slotData_q[fp_q][wrIdx_q] <= load_data;
    end
  end

  // Output decode: tile status, pending count and the gated PE data lanes.
  always_comb begin
    tile_ready     = (bankState_q[rp_q] == BANK_FULL);
    compute_active = active_q;
    active_bank_id = active_q ? rp_q : '0;
    active_count   = active_q ? bankCount_q[rp_q] : '0;
    pe_valid_mask  = '0;
    q_to_pes       = '0;
    tiles_pending  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bankState_q[b] == BANK_FULL) begin
        tiles_pending = tiles_pending + PEND_W'(1);
      end
    end
    for (int i = 0; i < NUM_PES; i++) begin
      if (active_q && (CNT_W'(i) < bankCount_q[rp_q])) begin
        pe_valid_mask[i]               = 1'b1;
        q_to_pes[i*Q_WIDTH +: Q_WIDTH] = slotData_q[rp_q][i];
      end
    end
  end

endmodule

// File: tb/tb_q_tile_ring_buffer.sv
// Bench for q_tile_ring_buffer (4 PEs, 3 banks, 16-bit vectors). Every expected
// tile presentation is queued when the start is issued. A monitor compares it
// on the cycle the DUT raises compute_active.

module tb_q_tile_ring_buffer;

  localparam int NP = 4;
  localparam int NB = 3;
  localparam int QW = 16;

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic [QW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          compute_start;
  logic          compute_done;
  logic          flush;
  logic          tile_ready;
  logic          compute_active;
  logic [1:0]    active_bank_id;
  logic [2:0]    active_count;
  logic [NP-1:0] pe_valid_mask;
  logic [NP*QW-1:0] q_to_pes;
  logic [1:0]    tiles_pending;

  typedef struct {
    logic [1:0]  id;
    logic [2:0]  cnt;
    logic [3:0]  mask;
    logic [63:0] q;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  logic prevActive = 1'b0;

  q_tile_ring_buffer #(
    .NUM_PES  (NP),
    .Q_WIDTH  (QW),
    .NUM_BANKS(NB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .compute_start (compute_start),
    .compute_done  (compute_done),
    .flush         (flush),
    .tile_ready    (tile_ready),
    .compute_active(compute_active),
    .active_bank_id(active_bank_id),
    .active_count  (active_count),
    .pe_valid_mask (pe_valid_mask),
    .q_to_pes      (q_to_pes),
    .tiles_pending (tiles_pending)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: on every rising edge of compute_active, compare against the oldest queued tile.
  always @(negedge clk) begin
    if (compute_active && !prevActive) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_activation", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("act_id",   64'(active_bank_id), 64'(e.id));
        checkOutput("act_cnt",  64'(active_count),   64'(e.cnt));
        checkOutput("act_mask", 64'(pe_valid_mask),  64'(e.mask));
        checkOutput("act_q",    q_to_pes,            e.q);
      end
    end
    prevActive = compute_active;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [1:0] id, input logic [2:0] cnt,
                         input logic [3:0] mask, input logic [63:0] q);
    exp_t e;
    e.id = id; e.cnt = cnt; e.mask = mask; e.q = q;
    expQ.push_back(e);
  endtask

  task automatic loadBeat(input logic [15:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulseStart();
    compute_start = 1'b1;
    tick();
    compute_start = 1'b0;
  endtask

  task automatic pulseDone();
    compute_done = 1'b1;
    tick();
    compute_done = 1'b0;
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_load_ready"}, 64'(load_ready),     64'd1);
    checkOutput({tag, "_tile_ready"}, 64'(tile_ready),     64'd0);
    checkOutput({tag, "_active"},     64'(compute_active), 64'd0);
    checkOutput({tag, "_id"},         64'(active_bank_id), 64'd0);
    checkOutput({tag, "_count"},      64'(active_count),   64'd0);
    checkOutput({tag, "_mask"},       64'(pe_valid_mask),  64'd0);
    checkOutput({tag, "_q"},          q_to_pes,            64'd0);
    checkOutput({tag, "_pending"},    64'(tiles_pending),  64'd0);
  endtask

  task automatic applyStimulus();
    // Reset state
    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    compute_start = 1'b0; compute_done = 1'b0; flush = 1'b0;
    tick(); tick();
    checkIdle("reset");
    rst = 1'b0;
    tick();

    // Full 4-vector tile in bank 0
    loadBeat(16'h0011, 1'b0);
    loadBeat(16'h0022, 1'b0);
    loadBeat(16'h0033, 1'b0);
    checkOutput("partial_tile_ready", 64'(tile_ready), 64'd0);
    loadBeat(16'h0044, 1'b0);
    checkOutput("full_tile_ready", 64'(tile_ready), 64'd1);
    checkOutput("full_pending", 64'(tiles_pending), 64'd1);
    pushExp(2'd0, 3'd4, 4'b1111, 64'h0044_0033_0022_0011);
    pulseStart();
    checkOutput("active_tile_ready", 64'(tile_ready), 64'd0);
    pulseDone();
    checkOutput("done_active", 64'(compute_active), 64'd0);
    pulseFlush();

    // Fill all three banks, then hold off beat 13 until bank 0 frees
    for (int k = 0; k < 12; k++) loadBeat(16'h0100 + 16'(k), 1'b0);
    checkOutput("ring_full_pending", 64'(tiles_pending), 64'd3);
    checkOutput("ring_full_load_ready", 64'(load_ready), 64'd0);
    load_valid = 1'b1; load_data = 16'h0D0D; load_last = 1'b0;
    tick();
    checkOutput("held_beat_pending", 64'(tiles_pending), 64'd3);
    pushExp(2'd0, 3'd4, 4'b1111, 64'h0103_0102_0101_0100);
    pulseStart();
    checkOutput("held_during_active", 64'(load_ready), 64'd0);
    pulseDone();
    checkOutput("freed_load_ready", 64'(load_ready), 64'd1);
    tick();
    load_valid = 1'b0;
    pushExp(2'd1, 3'd4, 4'b1111, 64'h0107_0106_0105_0104);
    pulseStart(); pulseDone();
    pushExp(2'd2, 3'd4, 4'b1111, 64'h010B_010A_0109_0108);
    pulseStart(); pulseDone();
    loadBeat(16'h0E0E, 1'b1);
    pushExp(2'd0, 3'd2, 4'b0011, 64'h0000_0000_0E0E_0D0D);
    pulseStart(); pulseDone();
    pulseFlush();

    // Stray load_last is ignored; short tile, then start and done in the same cycle
    load_last = 1'b1; tick(); load_last = 1'b0;
    checkOutput("stray_last_pending", 64'(tiles_pending), 64'd0);
    loadBeat(16'h00A1, 1'b0);
    loadBeat(16'h00A2, 1'b1);
    pushExp(2'd0, 3'd2, 4'b0011, 64'h0000_0000_00A2_00A1);
    pulseStart();
    loadBeat(16'h00B1, 1'b0);
    loadBeat(16'h00B2, 1'b0);
    loadBeat(16'h00B3, 1'b0);
    loadBeat(16'h00B4, 1'b0);
    compute_start = 1'b1; compute_done = 1'b1;
    tick();
    compute_start = 1'b0; compute_done = 1'b0;
    checkOutput("startdone_active", 64'(compute_active), 64'd0);
    checkOutput("startdone_tile_ready", 64'(tile_ready), 64'd1);
    pushExp(2'd1, 3'd4, 4'b1111, 64'h00B4_00B3_00B2_00B1);
    pulseStart();
    pulseDone();
    pulseFlush();

    // Flush with bank 0 active, bank 1 full, bank 2 filling and a beat in flight
    for (int k = 0; k < 4; k++) loadBeat(16'h00C1 + 16'(k), 1'b0);
    pushExp(2'd0, 3'd4, 4'b1111, 64'h00C4_00C3_00C2_00C1);
    pulseStart();
    for (int k = 0; k < 4; k++) loadBeat(16'h00D1 + 16'(k), 1'b0);
    loadBeat(16'h00E1, 1'b0);
    loadBeat(16'h00E2, 1'b0);
    checkOutput("preflush_pending", 64'(tiles_pending), 64'd1);
    flush = 1'b1; load_valid = 1'b1; load_data = 16'h00E3;
    tick();
    flush = 1'b0; load_valid = 1'b0;
    checkIdle("flush");
    loadBeat(16'h00F1, 1'b0);
    loadBeat(16'h00F2, 1'b1);
    pushExp(2'd0, 3'd2, 4'b0011, 64'h0000_0000_00F2_00F1);
    pulseStart(); pulseDone();
    pulseFlush();

    // Asynchronous reset mid-compute and mid-fill
    for (int k = 0; k < 4; k++) loadBeat(16'h0031 + 16'(k), 1'b0);
    pushExp(2'd0, 3'd4, 4'b1111, 64'h0034_0033_0032_0031);
    pulseStart();
    loadBeat(16'h0041, 1'b0);
    loadBeat(16'h0042, 1'b0);
    #2 rst = 1'b1;
    #1 checkIdle("async_rst");
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) loadBeat(16'h0051 + 16'(k), 1'b0);
    checkOutput("post_rst_pending", 64'(tiles_pending), 64'd1);
    pushExp(2'd0, 3'd4, 4'b1111, 64'h0054_0053_0052_0051);
    pulseStart(); pulseDone();
    tick();
  endtask

  initial begin
    applyStimulus();
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
